// File: rtl/seq_div8by4.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seq_div8by4
// Purpose  : Sequential unsigned restoring divider. It divides a DW-bit
//            dividend by a VW-bit divisor and produces one quotient bit per
//            clock. Handshake is start / busy / done.
// Ports    : clk          rising-edge clock
//            rst_n        asynchronous active-low reset
//            i_start      request, sampled only in IDLE
//            i_dividend   DW-bit numerator, captured with an accepted start
//            i_divisor    VW-bit denominator, captured with an accepted start
//            o_quotient   DW-bit result, held until the next result
//            o_remainder  VW-bit result, held until the next result
//            o_busy       high while RUN or DONE
//            o_done       one-cycle completion pulse
//            o_dbz        divide-by-zero flag (trap build only, else 0)
// Config   : DIV_BY_ZERO_TRAP_EN - when defined, a zero divisor bypasses the
//            iteration and completes one cycle after start with o_dbz=1.
// Revision : 1.0 - initial release
// ============================================================================
module seq_div8by4 #(
   parameter int DW = 8,
   parameter int VW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_start,
   input  logic [DW-1:0] i_dividend,
   input  logic [VW-1:0] i_divisor,
   output logic [DW-1:0] o_quotient,
   output logic [VW-1:0] o_remainder,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_dbz
);

   localparam int            CW     = (DW > 1) ? $clog2(DW) : 1;
   localparam logic [CW-1:0] c_last = CW'(DW - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_next;

   logic [DW-1:0] r_dvd;    // dividend bits shift out the top, quotient bits in at the bottom
   logic [VW-1:0] r_dvs;
   logic [VW-1:0] r_prem;   // kept partial remainder, always < divisor for a nonzero divisor
   logic [CW-1:0] r_cnt;
   logic [DW-1:0] r_quot;
   logic [VW-1:0] r_rem;

   logic          w_accept;
   logic          w_last;
   logic [VW:0]   w_shift;
   logic          w_qbit;
   logic [VW-1:0] w_diff;
   logic [VW-1:0] w_prem_nxt;
   logic [DW-1:0] w_dvd_nxt;

   assign w_accept = (r_state == S_IDLE) && i_start;
   assign w_last   = (r_cnt == c_last);

   // Restoring step on the (VW+1)-bit shifted partial remainder. When the
   // trial subtraction succeeds the true difference is below the divisor, so
   // its low VW bits are exact and the modular subtraction is sufficient.
   // With a zero divisor every trial succeeds, giving an all-ones quotient
   // and the low dividend bits as remainder.
   assign w_shift    = {r_prem, r_dvd[DW-1]};
   assign w_qbit     = (w_shift >= {1'b0, r_dvs});
   assign w_diff     = w_shift[VW-1:0] - r_dvs;
   assign w_prem_nxt = w_qbit ? w_diff : w_shift[VW-1:0];
   assign w_dvd_nxt  = {r_dvd[DW-2:0], w_qbit};

`ifdef DIV_BY_ZERO_TRAP_EN
   logic w_zero_div;
   logic r_dbz;
   assign w_zero_div = (i_divisor == '0);
`endif

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
`ifdef DIV_BY_ZERO_TRAP_EN
               w_next = w_zero_div ? S_DONE : S_RUN;
`else
               w_next = S_RUN;
`endif
            end
         end
         S_RUN: begin
            if (w_last) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath and result registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dvd  <= '0;
         r_dvs  <= '0;
         r_prem <= '0;
         r_cnt  <= '0;
         r_quot <= '0;
         r_rem  <= '0;
`ifdef DIV_BY_ZERO_TRAP_EN
         r_dbz  <= 1'b0;
`endif
      end else begin
         if (w_accept) begin
            r_dvd  <= i_dividend;
            r_dvs  <= i_divisor;
            r_prem <= '0;
            r_cnt  <= '0;
`ifdef DIV_BY_ZERO_TRAP_EN
            r_dbz  <= 1'b0;
            if (w_zero_div) begin
               // Short-circuit produces the same values the iteration would.
               r_quot <= '1;
               r_rem  <= i_dividend[VW-1:0];
               r_dbz  <= 1'b1;
            end
`endif
         end else if (r_state == S_RUN) begin
            r_dvd  <= w_dvd_nxt;
            r_prem <= w_prem_nxt;
            r_cnt  <= r_cnt + CW'(1);
            if (w_last) begin
               r_quot <= w_dvd_nxt;
               r_rem  <= w_prem_nxt;
            end
         end
      end
   end

   assign o_quotient  = r_quot;
   assign o_remainder = r_rem;
   assign o_busy      = (r_state != S_IDLE);
   assign o_done      = (r_state == S_DONE);
`ifdef DIV_BY_ZERO_TRAP_EN
   assign o_dbz       = r_dbz;
`else
   assign o_dbz       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_div8by4.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_seq_div8by4
// Purpose  : Directed self-checking bench for seq_div8by4. Edge E0 is the
//            edge that samples start; done_edge is the index k of the edge
//            E(k) after which done is first seen (8 normally, 0 for the
//            divide-by-zero trap, i.e. done in the cycle right after start).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_div8by4;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] dvd;
   logic [3:0] dvs;
   logic [7:0] quot;
   logic [3:0] rem;
   logic       busy;
   logic       done;
   logic       dbz;

   int total;
   int bad;

   seq_div8by4 #(.DW(8), .VW(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_start     (start),
      .i_dividend  (dvd),
      .i_divisor   (dvs),
      .o_quotient  (quot),
      .o_remainder (rem),
      .o_busy      (busy),
      .o_done      (done),
      .o_dbz       (dbz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Run one division; returns observations only, callers compare.
   task automatic do_div(input logic [7:0] a, input logic [3:0] b,
                         output logic [7:0] q, output logic [3:0] r,
                         output logic dz, output int done_edge,
                         output logic pulse_ok, output logic held);
      logic [7:0] q0;
      logic [3:0] r0;
      q = 'x; r = 'x; dz = 'x; done_edge = -1; pulse_ok = 1'b0; held = 1'b1;
      @(negedge clk);
      q0 = quot; r0 = rem;
      start = 1'b1; dvd = a; dvs = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int n = 0; n <= 40 && done_edge < 0; n++) begin
         if (n > 0) begin
            @(posedge clk);
            #1;
         end
         if (done) begin
            done_edge = n;
            q = quot; r = rem; dz = dbz;
         end else if (quot !== q0 || rem !== r0) begin
            held = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      pulse_ok = !done && !busy;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #1;
      total++; if (quot !== 8'd0) begin bad++; $display("FAIL reset_quot got=%0d want=0", quot); end
      total++; if (rem !== 4'd0)  begin bad++; $display("FAIL reset_rem got=%0d want=0", rem); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
      total++; if (dbz !== 1'b0)  begin bad++; $display("FAIL reset_dbz got=%b want=0", dbz); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_inverse;
      logic [7:0] a_t[4] = '{8'd48, 8'd12, 8'd36, 8'd0};
      logic [3:0] b_t[4] = '{4'd8, 4'd6, 4'd3, 4'd1};
      logic [7:0] q_t[4] = '{8'd6, 8'd2, 8'd12, 8'd0};
      logic [7:0] q; logic [3:0] r; logic dz; int de; logic pok; logic hld;
      for (int i = 0; i < 4; i++) begin
         do_div(a_t[i], b_t[i], q, r, dz, de, pok, hld);
         total++; if (q !== q_t[i]) begin bad++; $display("FAIL inv_quot %0d/%0d got=%0d want=%0d", a_t[i], b_t[i], q, q_t[i]); end
         total++; if (r !== 4'd0)   begin bad++; $display("FAIL inv_rem %0d/%0d got=%0d want=0", a_t[i], b_t[i], r); end
         total++; if (de != 8)      begin bad++; $display("FAIL inv_latency %0d/%0d got=%0d want=8", a_t[i], b_t[i], de); end
         total++; if (pok !== 1'b1) begin bad++; $display("FAIL inv_pulse %0d/%0d got=%b want=1", a_t[i], b_t[i], pok); end
         total++; if (hld !== 1'b1) begin bad++; $display("FAIL inv_hold_during_run %0d/%0d got=%b want=1", a_t[i], b_t[i], hld); end
      end
   endtask

   task automatic test_nonexact;
      logic [7:0] a_t[4] = '{8'd200, 8'd255, 8'd5, 8'd255};
      logic [3:0] b_t[4] = '{4'd7, 4'd1, 4'd15, 4'd15};
      logic [7:0] q_t[4] = '{8'd28, 8'd255, 8'd0, 8'd17};
      logic [3:0] r_t[4] = '{4'd4, 4'd0, 4'd5, 4'd0};
      logic [7:0] q; logic [3:0] r; logic dz; int de; logic pok; logic hld;
      for (int i = 0; i < 4; i++) begin
         do_div(a_t[i], b_t[i], q, r, dz, de, pok, hld);
         total++; if (q !== q_t[i]) begin bad++; $display("FAIL ext_quot %0d/%0d got=%0d want=%0d", a_t[i], b_t[i], q, q_t[i]); end
         total++; if (r !== r_t[i]) begin bad++; $display("FAIL ext_rem %0d/%0d got=%0d want=%0d", a_t[i], b_t[i], r, r_t[i]); end
         total++; if (de != 8)      begin bad++; $display("FAIL ext_latency %0d/%0d got=%0d want=8", a_t[i], b_t[i], de); end
         total++; if (dz !== 1'b0)  begin bad++; $display("FAIL ext_dbz %0d/%0d got=%b want=0", a_t[i], b_t[i], dz); end
      end
   endtask

   task automatic test_div_by_zero;
      logic [7:0] q; logic [3:0] r; logic dz; int de; logic pok; logic hld;
      int   want_de;
      logic want_dz;
`ifdef DIV_BY_ZERO_TRAP_EN
      want_de = 0; want_dz = 1'b1;
`else
      want_de = 8; want_dz = 1'b0;
`endif
      do_div(8'd93, 4'd0, q, r, dz, de, pok, hld);
      total++; if (q !== 8'd255)  begin bad++; $display("FAIL dbz_quot got=%0d want=255", q); end
      total++; if (r !== 4'd13)   begin bad++; $display("FAIL dbz_rem got=%0d want=13", r); end
      total++; if (de != want_de) begin bad++; $display("FAIL dbz_latency got=%0d want=%0d", de, want_de); end
      total++; if (dz !== want_dz) begin bad++; $display("FAIL dbz_flag got=%b want=%b", dz, want_dz); end
      total++; if (pok !== 1'b1)  begin bad++; $display("FAIL dbz_pulse got=%b want=1", pok); end
      // flag stays until the next accepted start
      total++; if (dbz !== want_dz) begin bad++; $display("FAIL dbz_flag_hold got=%b want=%b", dbz, want_dz); end
      do_div(8'd48, 4'd8, q, r, dz, de, pok, hld);
      total++; if (dz !== 1'b0 || q !== 8'd6) begin bad++; $display("FAIL dbz_clear got dbz=%b q=%0d want dbz=0 q=6", dz, q); end
   endtask

   task automatic test_back_to_back;
      int seen;
      logic [7:0] q1; logic [3:0] r1;
      @(negedge clk);
      start = 1'b1; dvd = 8'd48; dvs = 4'd8;
      @(posedge clk);
      #1;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL hs_busy_at_start got=%b want=1", busy); end
      seen = -1; q1 = 'x; r1 = 'x;
      for (int n = 1; n <= 40 && seen < 0; n++) begin
         @(negedge clk);
         dvd = dvd + 8'd17; dvs = dvs + 4'd1;
         @(posedge clk);
         #1;
         if (done) begin seen = n; q1 = quot; r1 = rem; end
      end
      total++; if (seen != 8) begin bad++; $display("FAIL hs_first_latency got=%0d want=8", seen); end
      total++; if (q1 !== 8'd6 || r1 !== 4'd0) begin bad++; $display("FAIL hs_first_result got=%0d r%0d want=6 r0", q1, r1); end
      @(negedge clk);
      dvd = 8'd200; dvs = 4'd7;      // start still high through DONE
      @(posedge clk);
      #1;
      total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL hs_done_ignores_start got busy=%b done=%b want 0 0", busy, done); end
      @(posedge clk);
      #1;
      start = 1'b0;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL hs_first_idle_accept got=%b want=1", busy); end
      seen = -1;
      for (int n = 1; n <= 40 && seen < 0; n++) begin
         @(posedge clk);
         #1;
         if (done) begin seen = n; q1 = quot; r1 = rem; end
      end
      total++; if (seen != 8) begin bad++; $display("FAIL hs_second_latency got=%0d want=8", seen); end
      total++; if (q1 !== 8'd28 || r1 !== 4'd4) begin bad++; $display("FAIL hs_second_result got=%0d r%0d want=28 r4", q1, r1); end
      dvd = 8'd3; dvs = 4'd1;
      repeat (6) @(posedge clk);
      #1;
      total++; if (quot !== 8'd28 || rem !== 4'd4 || done !== 1'b0) begin bad++; $display("FAIL hs_idle_hold got=%0d r%0d done=%b want=28 r4 done=0", quot, rem, done); end
   endtask

   task automatic test_reset_mid;
      logic [7:0] q; logic [3:0] r; logic dz; int de; logic pok; logic hld;
      @(negedge clk);
      start = 1'b1; dvd = 8'd200; dvs = 4'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rst_mid_ctrl got busy=%b done=%b want 0 0", busy, done); end
      total++; if (quot !== 8'd0 || rem !== 4'd0 || dbz !== 1'b0) begin bad++; $display("FAIL rst_mid_data got q=%0d r=%0d dbz=%b want 0 0 0", quot, rem, dbz); end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      do_div(8'd48, 4'd8, q, r, dz, de, pok, hld);
      total++; if (q !== 8'd6 || r !== 4'd0 || de != 8) begin bad++; $display("FAIL rst_mid_recover got=%0d r%0d lat=%0d want=6 r0 lat=8", q, r, de); end
   endtask

   task automatic test_random;
      logic [7:0] a; logic [3:0] b;
      logic [7:0] q; logic [3:0] r; logic dz; int de; logic pok; logic hld;
      for (int i = 0; i < 1000; i++) begin
         a = 8'($urandom_range(0, 255));
         b = 4'($urandom_range(1, 15));
         do_div(a, b, q, r, dz, de, pok, hld);
         total++;
         if ((int'(q) * int'(b) + int'(r)) != int'(a) || r >= b || de != 8 || pok !== 1'b1) begin
            bad++;
            $display("FAIL rand %0d/%0d got=%0d r%0d lat=%0d pulse=%b want q*d+r=a r<d lat=8", a, b, q, r, de, pok);
         end
      end
   endtask

   initial begin
      total = 0; bad = 0;
      rst_n = 1'b0; start = 1'b0; dvd = 8'd0; dvs = 4'd0;
      test_reset;
      test_inverse;
      test_nonexact;
      test_div_by_zero;
      test_back_to_back;
      test_reset_mid;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
